// File: rtl/mem_pipe_pkg.sv
// mem_pipe_pkg -- shared types for the MEM pipeline stage.
//   state_e  : data-memory handshake FSM states (IDLE, BUSY)
//   exmem_t  : EX/MEM pipeline register fields
//   memwb_t  : MEM/WB pipeline register fields
//   DMEM_WAIT_MAX_DFLT : default data-memory wait limit in BUSY cycles
package mem_pipe_pkg;

  localparam int DMEM_WAIT_MAX_DFLT = 15;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  typedef struct packed {
    logic        valid;
    logic        read;
    logic        write;
    logic        reg_write;
    logic        mem_to_reg;
    logic [4:0]  dest;
    logic [31:0] alu;
    logic [31:0] wdata;
  } exmem_t;

  typedef struct packed {
    logic [31:0] wb_data;
    logic [4:0]  dest;
    logic        reg_write;
  } memwb_t;

endpackage

// File: rtl/mem_wait_timer.sv
// mem_wait_timer -- counts BUSY cycles of a data-memory access and flags
// the cycle on which the access has used up its wait budget.
//   clk, reset     : clock, async active-low reset
//   clr            : IDLE->BUSY transition this cycle; counter restarts at 0
//   busy           : FSM is BUSY with a live request
//   timeout        : this BUSY cycle is number DMEM_WAIT_MAX
module mem_wait_timer
  import mem_pipe_pkg::*;
#(
  parameter int DMEM_WAIT_MAX = DMEM_WAIT_MAX_DFLT
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic busy,
  output logic timeout
);

  // Counter holds 0..DMEM_WAIT_MAX-1; the value seen in the k-th BUSY cycle
  // is k-1, so the last allowed cycle is when it equals DMEM_WAIT_MAX-1.
  localparam int CW = (DMEM_WAIT_MAX < 2) ? 1 : $clog2(DMEM_WAIT_MAX);
  localparam logic [CW-1:0] LAST = CW'(DMEM_WAIT_MAX - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    timeout = busy & (cnt_q == LAST);
    cnt_d   = cnt_q;
    if (clr)                cnt_d = '0;
    else if (busy && !timeout) cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/mem_pipe_stage.sv
// mem_pipe_stage -- EX/MEM register, data-memory handshake and MEM/WB
// register of a 5-stage pipeline.
//   clk, reset            : clock, async active-low reset
//   ex_*                  : EX-stage results and control, captured when !stall
//   dmem_ready/dmem_rdata : memory handshake / load data
//   dmem_req/we/addr/wdata: memory request
//   ex_mem_alu_result     : EX/MEM ALU result (forwarding source)
//   mem_wb_*              : MEM/WB write-back value, register, enable
//   stall                 : freeze IF/ID/EX and EX/MEM
//   dmem_timeout          : sticky, set when an access is aborted by timeout
//   misalign_err          : sticky, misaligned memory op (only with
//                           MEM_PIPE_ALIGN_CHECK_EN defined, else tied 0)
// Optional feature macro: MEM_PIPE_ALIGN_CHECK_EN.
module mem_pipe_stage
  import mem_pipe_pkg::*;
#(
  parameter int DMEM_WAIT_MAX = DMEM_WAIT_MAX_DFLT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] ex_alu_result,
  input  logic [31:0] ex_alu_in_out,
  input  logic        ex_valid,
  input  logic        ex_mem_read,
  input  logic        ex_mem_write,
  input  logic        ex_reg_write,
  input  logic        ex_mem_to_reg,
  input  logic [4:0]  ex_dest_reg,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [31:0] ex_mem_alu_result,
  output logic [31:0] mem_wb_write_back_result,
  output logic [4:0]  mem_wb_dest_reg,
  output logic        mem_wb_reg_write,
  output logic        stall,
  output logic        dmem_timeout,
  output logic        misalign_err
);

  exmem_t exm_q, exm_d;
  memwb_t mwb_q, mwb_d;
  state_e state_q, state_d;
  logic   dmem_timeout_q, dmem_timeout_d;

  logic mem_op, misalign, req, done, enter, timeout, abort;

  // ---------------------------------------------------------------------
  // Request decode (registered state only)
  // ---------------------------------------------------------------------
  always_comb begin
    mem_op = exm_q.valid & (exm_q.read | exm_q.write);
`ifdef MEM_PIPE_ALIGN_CHECK_EN
    misalign = mem_op & (exm_q.alu[1:0] != 2'b00);
`else
    misalign = 1'b0;
`endif
    req   = mem_op & ~misalign & ((state_q == IDLE) | (state_q == BUSY));
    done  = req & dmem_ready;
    // Ready wins over timeout on the same cycle.
    abort = req & ~dmem_ready & timeout;
    enter = (state_q == IDLE) & req & ~dmem_ready;
  end

  mem_wait_timer #(
    .DMEM_WAIT_MAX(DMEM_WAIT_MAX)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clr    (enter),
    .busy   ((state_q == BUSY) & req),
    .timeout(timeout)
  );

  // Stall drops on the abort cycle so EX/MEM takes the next instruction.
  assign stall      = req & ~dmem_ready & ~timeout;
  assign dmem_req   = req;
  assign dmem_we    = exm_q.write;
  assign dmem_addr  = exm_q.alu;
  assign dmem_wdata = exm_q.wdata;

  assign ex_mem_alu_result        = exm_q.alu;
  assign mem_wb_write_back_result = mwb_q.wb_data;
  assign mem_wb_dest_reg          = mwb_q.dest;
  assign mem_wb_reg_write         = mwb_q.reg_write;
  assign dmem_timeout             = dmem_timeout_q;

  // ---------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (req && !dmem_ready) state_d = BUSY;
      BUSY: if (!req || dmem_ready || timeout) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // EX/MEM: capture when not stalled, hold otherwise
  // ---------------------------------------------------------------------
  always_comb begin
    exm_d = exm_q;
    if (!stall) begin
      exm_d.valid      = ex_valid;
      exm_d.read       = ex_mem_read;
      exm_d.write      = ex_mem_write;
      exm_d.reg_write  = ex_reg_write;
      exm_d.mem_to_reg = ex_mem_to_reg;
      exm_d.dest       = ex_dest_reg;
      exm_d.alu        = ex_alu_result;
      exm_d.wdata      = ex_alu_in_out;
    end
  end

  // ---------------------------------------------------------------------
  // MEM/WB: bubble (reg_write=0, data/dest held) unless a non-memory op
  // or a completed memory access retires this cycle.
  // ---------------------------------------------------------------------
  always_comb begin
    mwb_d           = mwb_q;
    mwb_d.reg_write = 1'b0;
    if (exm_q.valid && !misalign && (!mem_op || done)) begin
      mwb_d.wb_data   = (mem_op && exm_q.mem_to_reg) ? dmem_rdata : exm_q.alu;
      mwb_d.dest      = exm_q.dest;
      mwb_d.reg_write = exm_q.reg_write;
    end
  end

  assign dmem_timeout_d = dmem_timeout_q | abort;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      exm_q          <= '0;
      mwb_q          <= '0;
      dmem_timeout_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      exm_q          <= exm_d;
      mwb_q          <= mwb_d;
      dmem_timeout_q <= dmem_timeout_d;
    end
  end

`ifdef MEM_PIPE_ALIGN_CHECK_EN
  logic misalign_err_q, misalign_err_d;

  assign misalign_err_d = misalign_err_q | misalign;
  assign misalign_err   = misalign_err_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) misalign_err_q <= 1'b0;
    else        misalign_err_q <= misalign_err_d;
  end
`else
  assign misalign_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_pipe_stage.sv
module tb_mem_pipe_stage;

  logic        clk, reset;
  logic [31:0] ex_alu_result, ex_alu_in_out;
  logic        ex_valid, ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg;
  logic [4:0]  ex_dest_reg;
  logic        dmem_ready;
  logic [31:0] dmem_rdata;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata, ex_mem_alu_result, mem_wb_write_back_result;
  logic [4:0]  mem_wb_dest_reg;
  logic        mem_wb_reg_write, stall, dmem_timeout, misalign_err;

  int n_chk  = 0;
  int n_pass = 0;

  mem_pipe_stage #(.DMEM_WAIT_MAX(4)) dut (
    .clk(clk), .reset(reset),
    .ex_alu_result(ex_alu_result), .ex_alu_in_out(ex_alu_in_out),
    .ex_valid(ex_valid), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_reg_write(ex_reg_write), .ex_mem_to_reg(ex_mem_to_reg), .ex_dest_reg(ex_dest_reg),
    .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .ex_mem_alu_result(ex_mem_alu_result),
    .mem_wb_write_back_result(mem_wb_write_back_result),
    .mem_wb_dest_reg(mem_wb_dest_reg), .mem_wb_reg_write(mem_wb_reg_write),
    .stall(stall), .dmem_timeout(dmem_timeout), .misalign_err(misalign_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_ex(input logic v, input logic rd, input logic wr, input logic rw,
                          input logic m2r, input logic [4:0] dst,
                          input logic [31:0] alu, input logic [31:0] wd);
    ex_valid = v; ex_mem_read = rd; ex_mem_write = wr; ex_reg_write = rw;
    ex_mem_to_reg = m2r; ex_dest_reg = dst; ex_alu_result = alu; ex_alu_in_out = wd;
  endtask

  task automatic idle_ex();
    drive_ex(0, 0, 0, 0, 0, 5'd0, 32'h0, 32'h0);
  endtask

  task automatic test_reset();
    reset = 1'b0; dmem_ready = 1'b0; dmem_rdata = '0; idle_ex();
    #3;
    n_chk++; if ({stall, dmem_req, dmem_timeout, misalign_err, mem_wb_reg_write} !== 5'b0)
      $display("FAIL reset_flags: got %b want 00000", {stall, dmem_req, dmem_timeout, misalign_err, mem_wb_reg_write}); else n_pass++;
    n_chk++; if ({ex_mem_alu_result, mem_wb_write_back_result, dmem_addr, dmem_wdata} !== 128'h0)
      $display("FAIL reset_data: got %h want 0", {ex_mem_alu_result, mem_wb_write_back_result, dmem_addr, dmem_wdata}); else n_pass++;
    @(negedge clk); reset = 1'b1;
    tick();
  endtask

  task automatic test_alu();
    drive_ex(1, 0, 0, 1, 0, 5'd5, 32'h10, 32'h0);
    #1;
    n_chk++; if (stall !== 1'b0) $display("FAIL alu_stall0: got %b want 0", stall); else n_pass++;
    tick(); idle_ex(); #1;
    n_chk++; if (ex_mem_alu_result !== 32'h10) $display("FAIL alu_exm: got %h want 00000010", ex_mem_alu_result); else n_pass++;
    n_chk++; if (stall !== 1'b0 || dmem_req !== 1'b0) $display("FAIL alu_stall1: got stall=%b req=%b want 0 0", stall, dmem_req); else n_pass++;
    tick();
    n_chk++; if ({mem_wb_write_back_result, mem_wb_dest_reg, mem_wb_reg_write} !== {32'h10, 5'd5, 1'b1})
      $display("FAIL alu_wb: got %h/%0d/%b want 00000010/5/1", mem_wb_write_back_result, mem_wb_dest_reg, mem_wb_reg_write); else n_pass++;
    tick();
    n_chk++; if (mem_wb_reg_write !== 1'b0) $display("FAIL alu_bubble: got %b want 0", mem_wb_reg_write); else n_pass++;
  endtask

  task automatic test_back_to_back();
    drive_ex(1, 0, 0, 1, 0, 5'd1, 32'hA, 32'h0);
    tick(); drive_ex(1, 0, 0, 1, 0, 5'd2, 32'hB, 32'h0);
    tick(); idle_ex(); #1;
    n_chk++; if ({mem_wb_write_back_result, mem_wb_dest_reg, ex_mem_alu_result} !== {32'hA, 5'd1, 32'hB})
      $display("FAIL b2b_first: got %h/%0d exm=%h want 0000000a/1 exm=0000000b", mem_wb_write_back_result, mem_wb_dest_reg, ex_mem_alu_result); else n_pass++;
    tick();
    n_chk++; if ({mem_wb_write_back_result, mem_wb_dest_reg, mem_wb_reg_write} !== {32'hB, 5'd2, 1'b1})
      $display("FAIL b2b_second: got %h/%0d/%b want 0000000b/2/1", mem_wb_write_back_result, mem_wb_dest_reg, mem_wb_reg_write); else n_pass++;
    tick();
  endtask

  task automatic test_load_wait();
    dmem_ready = 1'b0;
    drive_ex(1, 1, 0, 1, 1, 5'd7, 32'h100, 32'h0);
    tick(); drive_ex(1, 0, 0, 1, 0, 5'd9, 32'h55, 32'h0); #1;
    n_chk++; if ({dmem_req, dmem_we, stall, dmem_addr} !== {3'b101, 32'h100})
      $display("FAIL load_req: got req=%b we=%b stall=%b addr=%h want 1 0 1 00000100", dmem_req, dmem_we, stall, dmem_addr); else n_pass++;
    for (int i = 0; i < 2; i++) begin
      tick(); #1;
      n_chk++; if ({stall, mem_wb_reg_write, ex_mem_alu_result} !== {2'b10, 32'h100})
        $display("FAIL load_stall%0d: got stall=%b rw=%b exm=%h want 1 0 00000100", i, stall, mem_wb_reg_write, ex_mem_alu_result); else n_pass++;
    end
    tick(); dmem_ready = 1'b1; dmem_rdata = 32'hDEADBEEF; #1;
    n_chk++; if (stall !== 1'b0 || mem_wb_reg_write !== 1'b0)
      $display("FAIL load_release: got stall=%b rw=%b want 0 0", stall, mem_wb_reg_write); else n_pass++;
    tick(); dmem_ready = 1'b0; idle_ex(); #1;
    n_chk++; if ({mem_wb_write_back_result, mem_wb_dest_reg, mem_wb_reg_write, ex_mem_alu_result} !== {32'hDEADBEEF, 5'd7, 1'b1, 32'h55})
      $display("FAIL load_wb: got %h/%0d/%b exm=%h want deadbeef/7/1 exm=00000055", mem_wb_write_back_result, mem_wb_dest_reg, mem_wb_reg_write, ex_mem_alu_result); else n_pass++;
    tick();
    n_chk++; if ({mem_wb_write_back_result, mem_wb_dest_reg, mem_wb_reg_write} !== {32'h55, 5'd9, 1'b1})
      $display("FAIL load_next: got %h/%0d/%b want 00000055/9/1", mem_wb_write_back_result, mem_wb_dest_reg, mem_wb_reg_write); else n_pass++;
    tick();
  endtask

  task automatic test_store();
    drive_ex(1, 0, 1, 0, 0, 5'd0, 32'h200, 32'h12345678);
    tick(); idle_ex(); dmem_ready = 1'b1; #1;
    n_chk++; if ({dmem_req, dmem_we, stall, dmem_addr, dmem_wdata} !== {3'b110, 32'h200, 32'h12345678})
      $display("FAIL store_req: got req=%b we=%b stall=%b addr=%h wd=%h want 1 1 0 00000200 12345678", dmem_req, dmem_we, stall, dmem_addr, dmem_wdata); else n_pass++;
    tick(); #1;
    n_chk++; if ({dmem_req, stall, mem_wb_reg_write} !== 3'b000)
      $display("FAIL store_after: got req=%b stall=%b rw=%b want 0 0 0", dmem_req, stall, mem_wb_reg_write); else n_pass++;
    tick(); dmem_ready = 1'b0; #1;
    n_chk++; if ({stall, mem_wb_reg_write, dmem_timeout} !== 3'b000)
      $display("FAIL ready_ignored: got stall=%b rw=%b to=%b want 0 0 0", stall, mem_wb_reg_write, dmem_timeout); else n_pass++;
  endtask

  task automatic test_ready_at_timeout();
    drive_ex(1, 1, 0, 1, 1, 5'd4, 32'h104, 32'h0);
    tick(); idle_ex(); #1;
    n_chk++; if (stall !== 1'b1) $display("FAIL rdy_to_s1: got %b want 1", stall); else n_pass++;
    for (int i = 1; i <= 3; i++) begin
      tick(); #1;
      n_chk++; if (stall !== 1'b1) $display("FAIL rdy_to_busy%0d: got %b want 1", i, stall); else n_pass++;
    end
    tick(); dmem_ready = 1'b1; dmem_rdata = 32'hCAFEF00D; #1;
    n_chk++; if (stall !== 1'b0) $display("FAIL rdy_to_release: got %b want 0", stall); else n_pass++;
    tick(); dmem_ready = 1'b0; #1;
    n_chk++; if ({mem_wb_write_back_result, mem_wb_dest_reg, mem_wb_reg_write, dmem_timeout} !== {32'hCAFEF00D, 5'd4, 2'b10})
      $display("FAIL rdy_to_wb: got %h/%0d/%b to=%b want cafef00d/4/1 to=0", mem_wb_write_back_result, mem_wb_dest_reg, mem_wb_reg_write, dmem_timeout); else n_pass++;
    tick();
  endtask

  task automatic test_timeout();
    drive_ex(1, 1, 0, 1, 1, 5'd6, 32'h300, 32'h0);
    tick(); idle_ex(); #1;
    n_chk++; if (stall !== 1'b1) $display("FAIL to_s1: got %b want 1", stall); else n_pass++;
    for (int i = 1; i <= 3; i++) begin
      tick(); #1;
      n_chk++; if (stall !== 1'b1) $display("FAIL to_busy%0d: got %b want 1", i, stall); else n_pass++;
    end
    tick(); #1;
    n_chk++; if ({stall, dmem_req, dmem_timeout} !== 3'b010)
      $display("FAIL to_abort: got stall=%b req=%b to=%b want 0 1 0", stall, dmem_req, dmem_timeout); else n_pass++;
    tick(); #1;
    n_chk++; if ({dmem_timeout, mem_wb_reg_write, dmem_req, stall} !== 4'b1000)
      $display("FAIL to_after: got to=%b rw=%b req=%b stall=%b want 1 0 0 0", dmem_timeout, mem_wb_reg_write, dmem_req, stall); else n_pass++;
    tick();
    n_chk++; if (dmem_timeout !== 1'b1) $display("FAIL to_sticky: got %b want 1", dmem_timeout); else n_pass++;
  endtask

  task automatic test_reset_busy();
    drive_ex(1, 1, 0, 1, 1, 5'd8, 32'h400, 32'h0);
    tick(); idle_ex();
    tick(); #1;
    n_chk++; if ({stall, dmem_req} !== 2'b11) $display("FAIL rst_busy_pre: got stall=%b req=%b want 1 1", stall, dmem_req); else n_pass++;
    #2 reset = 1'b0; #1;
    n_chk++; if ({dmem_req, stall, dmem_timeout, mem_wb_reg_write} !== 4'b0000)
      $display("FAIL rst_busy_flags: got req=%b stall=%b to=%b rw=%b want 0 0 0 0", dmem_req, stall, dmem_timeout, mem_wb_reg_write); else n_pass++;
    n_chk++; if ({mem_wb_write_back_result, mem_wb_dest_reg, ex_mem_alu_result} !== 69'h0)
      $display("FAIL rst_busy_data: got wb=%h dst=%0d exm=%h want 0", mem_wb_write_back_result, mem_wb_dest_reg, ex_mem_alu_result); else n_pass++;
    #2 reset = 1'b1;
    tick(); #1;
    n_chk++; if ({dmem_req, stall, mem_wb_reg_write} !== 3'b000)
      $display("FAIL rst_busy_after: got req=%b stall=%b rw=%b want 0 0 0", dmem_req, stall, mem_wb_reg_write); else n_pass++;
  endtask

  task automatic test_align();
    drive_ex(1, 1, 0, 1, 1, 5'd2, 32'h102, 32'h0);
`ifdef MEM_PIPE_ALIGN_CHECK_EN
    tick(); idle_ex(); #1;
    n_chk++; if ({dmem_req, stall, misalign_err} !== 3'b000)
      $display("FAIL align_req: got req=%b stall=%b mis=%b want 0 0 0", dmem_req, stall, misalign_err); else n_pass++;
    tick(); #1;
    n_chk++; if ({misalign_err, mem_wb_reg_write} !== 2'b10)
      $display("FAIL align_flag: got mis=%b rw=%b want 1 0", misalign_err, mem_wb_reg_write); else n_pass++;
`else
    tick(); idle_ex(); dmem_ready = 1'b1; dmem_rdata = 32'h0BADF00D; #1;
    n_chk++; if ({dmem_req, stall, misalign_err, dmem_addr} !== {3'b100, 32'h102})
      $display("FAIL align_pass: got req=%b stall=%b mis=%b addr=%h want 1 0 0 00000102", dmem_req, stall, misalign_err, dmem_addr); else n_pass++;
    tick(); dmem_ready = 1'b0; #1;
    n_chk++; if ({mem_wb_write_back_result, mem_wb_reg_write, misalign_err} !== {32'h0BADF00D, 2'b10})
      $display("FAIL align_wb: got %h/%b mis=%b want 0badf00d/1 mis=0", mem_wb_write_back_result, mem_wb_reg_write, misalign_err); else n_pass++;
`endif
    tick();
  endtask

  initial begin
    test_reset();
    test_alu();
    test_back_to_back();
    test_load_wait();
    test_store();
    test_ready_at_timeout();
    test_timeout();
    test_reset_busy();
    test_align();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
